dram_device_model: RTL and testbench
====================================

Name: dram_device_model

Overview:
Cycle-accurate, synthesizable responder at the far end of the DRAM command bus driven by dram_controller. It decodes cs_n/ras_n/cas_n/we_n commands, tracks one open row per bank, and stores and returns data. It runs fixed-length refresh cycles and signals their completion with a one-cycle pulse. The block is used as the memory behind the controller in system benches and as an FPGA stand-in.

Parameters:
NUMBER_OF_COLUMNS, 8, columns per row
NUMBER_OF_ROWS, 128, rows per bank
NUMBER_OF_BANKS, 8, banks
DRAM_DATA_WIDTH, 8, data word width
REFRESH_CYCLES, 4, cycles from REFRESH command to refresh_done pulse; must be ≥1
COLUMN_WIDTH, ROW_WIDTH, BANK_ID_WIDTH, derived, clog2 of the counts above
DRAM_ADDR_WIDTH, derived, max(ROW_WIDTH, COLUMN_WIDTH)

Ports:
u_clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
dram_clk_en  in  1  clock enable; low freezes the device
dram_cs_n  in  1  chip select, active-low
dram_ras_n  in  1  row address strobe
dram_cas_n  in  1  column address strobe
dram_we_n  in  1  write enable
dram_addr  in  DRAM_ADDR_WIDTH  row address (ACTIVATE) or column address (READ/WRITE)
dram_bank_id  in  BANK_ID_WIDTH  target bank
dram_wr_data  in  DRAM_DATA_WIDTH  write data
dram_rd_data  out  DRAM_DATA_WIDTH  read data, registered
dram_refresh_done  out  1  one-cycle refresh completion pulse
bank_open  out  NUMBER_OF_BANKS  per-bank row-open status
cmd_error  out  1  one-cycle pulse on an illegal or protocol-violating command

Behaviour:
- Command decode is valid only when cs_n=0 and clk_en=1; otherwise the cycle is a NOP. Encodings as {ras_n,cas_n,we_n}:
  - 111 NOP
  - 011 ACTIVATE
  - 101 READ
  - 100 WRITE
  - 010 PRECHARGE
  - 001 REFRESH
  - 000 and 110 are illegal: cmd_error pulses and there is no other effect.
- clk_en=0 holds all state: outputs, refresh counter, open rows.
- Reset values: rd_data=0, refresh_done=0, cmd_error=0, bank_open=0, FSM=S_IDLE, refresh counter=0. Storage contents are not reset.
- Row tracking: open_row[bank] holds addr[ROW_WIDTH-1:0]. Column index is addr[COLUMN_WIDTH-1:0]; upper address bits are ignored.
- ACTIVATE to a closed bank sets bank_open[b] and latches the row. ACTIVATE to an open bank raises cmd_error; the row is unchanged.
- PRECHARGE clears bank_open[bank_id]. PRECHARGE to an already-closed bank is a legal no-op.
- WRITE to an open bank stores wr_data at (bank, open_row, col) at the end of the command cycle.
- READ to an open bank updates rd_data at the edge ending the command cycle, so data is valid the following cycle (latency 1). rd_data holds until the next legal READ.
- WRITE then READ of the same location in back-to-back cycles returns the new data.
- READ or WRITE to a closed bank raises cmd_error; there is no access and rd_data is unchanged.
- FSM states: S_IDLE, S_REFRESH.
  - S_IDLE + REFRESH: close all banks (implicit precharge-all; bank_open=0 next cycle), load counter=REFRESH_CYCLES-1, go to S_REFRESH.
  - S_REFRESH: counter decrements each enabled cycle. When the counter is 0, refresh_done=1 for exactly that cycle, then return to S_IDLE.
  - Pulse timing: a REFRESH command in cycle T gives refresh_done high in cycle T+REFRESH_CYCLES.
  - In S_REFRESH a repeated REFRESH command (the controller holds it until done) is a continuation, not an error. Any other non-NOP command raises cmd_error and is ignored.
  - After return to S_IDLE, a new REFRESH in the next cycle starts a new refresh.
- cmd_error is registered and goes high the cycle after the offending command.
- Reset mid-refresh: the next cycle is S_IDLE, done=0, and all banks are closed.

Decomposition:
- Package dram_pkg:
  - command localparams CMD_NOP/ACT/RD/WR/PRE/REF (3-bit {ras_n,cas_n,we_n})
  - device state typedef
  - shared geometry defaults, to be shared with dram_controller
- Sub-module dram_storage_array: synchronous single-port RAM, NUMBER_OF_BANKS*NUMBER_OF_ROWS*NUMBER_OF_COLUMNS words, flat index {bank,row,col}, write-first, registered read.

Test Plan:
- Reset then ACT bank2 row 0x15, WR col 3 data 0xA5, PRE bank2, ACT bank2 row 0x15, RD col 3 -> rd_data=0xA5 one cycle after RD; bank_open=0x04 after ACT; cmd_error stays 0.
- RD bank5 while closed -> cmd_error pulses 1 cycle, rd_data unchanged; ACT bank5 twice -> second ACT raises cmd_error, open row keeps its first value.
- ACT banks 0,1,7, REFRESH held until done, REFRESH_CYCLES=4 -> bank_open=0 the cycle after REFRESH, refresh_done high exactly in cycle T+4 for one cycle.
- ACT issued during refresh -> cmd_error pulse, bank_open stays 0, refresh_done timing unchanged.
- clk_en=0 for 3 cycles mid-refresh -> done pulse delayed by exactly 3 cycles; WR command with clk_en=0 does not modify storage.
- rst_n low during S_REFRESH with banks open -> next cycle refresh_done=0, bank_open=0, rd_data=0; cmd encoding 000 -> cmd_error only.

Source files
------------

// File: rtl/dram_pkg.sv
// Shared definitions for the DRAM command bus: geometry defaults, command
// encodings and the device-side state type.
package dram_pkg;

   // Geometry defaults, also used by dram_controller.
   localparam int DEF_NUMBER_OF_COLUMNS = 8;
   localparam int DEF_NUMBER_OF_ROWS    = 128;
   localparam int DEF_NUMBER_OF_BANKS   = 8;
   localparam int DEF_DRAM_DATA_WIDTH   = 8;
   localparam int DEF_REFRESH_CYCLES    = 4;

   // Commands encoded as {ras_n, cas_n, we_n}.
   localparam logic [2:0] CMD_NOP = 3'b111;
   localparam logic [2:0] CMD_ACT = 3'b011;
   localparam logic [2:0] CMD_RD  = 3'b101;
   localparam logic [2:0] CMD_WR  = 3'b100;
   localparam logic [2:0] CMD_PRE = 3'b010;
   localparam logic [2:0] CMD_REF = 3'b001;

   typedef enum logic {
      S_IDLE,
      S_REFRESH
   } dev_state_t;

endpackage

// File: rtl/dram_storage_array.sv
// Single-port word storage behind the device model. Flat index is
// {bank, row, col}. Read data is registered and only changes on a read.
module dram_storage_array #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 13
) (
   input  logic                  u_clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic [DATA_WIDTH-1:0] rd_data
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rd_data_q;

   // Write port; contents survive reset on purpose.
   always_ff @(posedge u_clk) begin
      if (wr_en) begin
         mem_q[addr] <= wr_data;
      end
   end

   // Registered read, write-first if both enables coincide; holds between reads.
   always_ff @(posedge u_clk) begin
      if (!rst_n) begin
         rd_data_q <= '0;
      end else if (rd_en) begin
         rd_data_q <= wr_en ? wr_data : mem_q[addr];
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/dram_device_model.sv
// Far-end DRAM responder: decodes bus commands, tracks one open row per
// bank, stores/returns data and runs fixed-length refresh cycles.
module dram_device_model
   import dram_pkg::*;
#(
   parameter int NUMBER_OF_COLUMNS = DEF_NUMBER_OF_COLUMNS,
   parameter int NUMBER_OF_ROWS    = DEF_NUMBER_OF_ROWS,
   parameter int NUMBER_OF_BANKS   = DEF_NUMBER_OF_BANKS,
   parameter int DRAM_DATA_WIDTH   = DEF_DRAM_DATA_WIDTH,
   parameter int REFRESH_CYCLES    = DEF_REFRESH_CYCLES,
   parameter int COLUMN_WIDTH      = $clog2(NUMBER_OF_COLUMNS),
   parameter int ROW_WIDTH         = $clog2(NUMBER_OF_ROWS),
   parameter int BANK_ID_WIDTH     = $clog2(NUMBER_OF_BANKS),
   parameter int DRAM_ADDR_WIDTH   = (ROW_WIDTH > COLUMN_WIDTH) ? ROW_WIDTH : COLUMN_WIDTH
) (
   input  logic                       u_clk,
   input  logic                       rst_n,
   input  logic                       dram_clk_en,
   input  logic                       dram_cs_n,
   input  logic                       dram_ras_n,
   input  logic                       dram_cas_n,
   input  logic                       dram_we_n,
   input  logic [DRAM_ADDR_WIDTH-1:0] dram_addr,
   input  logic [BANK_ID_WIDTH-1:0]   dram_bank_id,
   input  logic [DRAM_DATA_WIDTH-1:0] dram_wr_data,
   output logic [DRAM_DATA_WIDTH-1:0] dram_rd_data,
   output logic                       dram_refresh_done,
   output logic [NUMBER_OF_BANKS-1:0] bank_open,
   output logic                       cmd_error
);

   localparam int CNT_W  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
   localparam int MEM_AW = BANK_ID_WIDTH + ROW_WIDTH + COLUMN_WIDTH;

   dev_state_t                 state_q, state_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic [NUMBER_OF_BANKS-1:0] bank_open_q, bank_open_d;
   logic [ROW_WIDTH-1:0]       open_row_q [NUMBER_OF_BANKS];
   logic [ROW_WIDTH-1:0]       open_row_d [NUMBER_OF_BANKS];
   logic                       cmd_error_q, cmd_error_d;
   logic                       refresh_done_q, refresh_done_d;
   logic                       mem_wr_en, mem_rd_en;
   logic [2:0]                 cmd;
   logic [ROW_WIDTH-1:0]       row_addr;
   logic [COLUMN_WIDTH-1:0]    col_addr;
   logic [MEM_AW-1:0]          mem_addr;

   assign cmd      = {dram_ras_n, dram_cas_n, dram_we_n};
   assign row_addr = dram_addr[ROW_WIDTH-1:0];
   assign col_addr = dram_addr[COLUMN_WIDTH-1:0];
   assign mem_addr = {dram_bank_id, open_row_q[dram_bank_id], col_addr};

   // Command decode and refresh sequencing; everything holds while clk_en is low.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      bank_open_d    = bank_open_q;
      open_row_d     = open_row_q;
      cmd_error_d    = cmd_error_q;
      refresh_done_d = refresh_done_q;
      mem_wr_en      = 1'b0;
      mem_rd_en      = 1'b0;
      if (dram_clk_en && rst_n) begin
         cmd_error_d = 1'b0;
         case (state_q)
            S_IDLE: begin
               if (!dram_cs_n) begin
                  case (cmd)
                     CMD_NOP: ;
                     CMD_ACT: begin
                        if (bank_open_q[dram_bank_id]) begin
                           cmd_error_d = 1'b1;
                        end else begin
                           bank_open_d[dram_bank_id] = 1'b1;
                           open_row_d[dram_bank_id]  = row_addr;
                        end
                     end
                     CMD_RD: begin
                        if (bank_open_q[dram_bank_id]) mem_rd_en = 1'b1;
                        else                           cmd_error_d = 1'b1;
                     end
                     CMD_WR: begin
                        if (bank_open_q[dram_bank_id]) mem_wr_en = 1'b1;
                        else                           cmd_error_d = 1'b1;
                     end
                     CMD_PRE: bank_open_d[dram_bank_id] = 1'b0;
                     CMD_REF: begin
                        // Refresh implies precharge-all.
                        bank_open_d = '0;
                        cnt_d       = CNT_W'(REFRESH_CYCLES - 1);
                        state_d     = S_REFRESH;
                     end
                     default: cmd_error_d = 1'b1;
                  endcase
               end
            end
            S_REFRESH: begin
               if (cnt_q == '0) state_d = S_IDLE;
               else             cnt_d   = cnt_q - CNT_W'(1);
               // A held REFRESH is the controller waiting for done, not an error.
               if (!dram_cs_n && (cmd != CMD_NOP) && (cmd != CMD_REF)) begin
                  cmd_error_d = 1'b1;
               end
            end
            default: state_d = S_IDLE;
         endcase
         // Done is high during the refresh cycle whose counter reads zero.
         refresh_done_d = (state_d == S_REFRESH) && (cnt_d == '0);
      end
   end

   // Control state registers with synchronous active-low reset.
   always_ff @(posedge u_clk) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         cnt_q          <= '0;
         bank_open_q    <= '0;
         cmd_error_q    <= 1'b0;
         refresh_done_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         bank_open_q    <= bank_open_d;
         cmd_error_q    <= cmd_error_d;
         refresh_done_q <= refresh_done_d;
      end
   end

   // Open-row latches are only meaningful while the bank is open, so no reset.
   always_ff @(posedge u_clk) begin
      open_row_q <= open_row_d;
   end

   dram_storage_array #(
      .DATA_WIDTH (DRAM_DATA_WIDTH),
      .ADDR_WIDTH (MEM_AW)
   ) u_storage (
      .u_clk   (u_clk),
      .rst_n   (rst_n),
      .wr_en   (mem_wr_en),
      .rd_en   (mem_rd_en),
      .addr    (mem_addr),
      .wr_data (dram_wr_data),
      .rd_data (dram_rd_data)
   );

   assign dram_refresh_done = refresh_done_q;
   assign bank_open         = bank_open_q;
   assign cmd_error         = cmd_error_q;

endmodule

// File: tb/tb_dram_device_model.sv
// Bench for dram_device_model: directed vector table, hand-written reset
// sequence, then random traffic against a transaction-level model.
module tb_dram_device_model;
   import dram_pkg::*;

   localparam int RC   = 4;
   localparam int COLS = 8;
   localparam int ROWS = 128;

   logic       u_clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clk_en = 1'b1;
   logic       cs_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
   logic [6:0] addr = '0;
   logic [2:0] bank = '0;
   logic [7:0] wr_data = '0;
   logic [7:0] rd_data, bank_open;
   logic       refresh_done, cmd_error;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 u_clk = ~u_clk;

   dram_device_model dut (
      .u_clk             (u_clk),
      .rst_n             (rst_n),
      .dram_clk_en       (clk_en),
      .dram_cs_n         (cs_n),
      .dram_ras_n        (ras_n),
      .dram_cas_n        (cas_n),
      .dram_we_n         (we_n),
      .dram_addr         (addr),
      .dram_bank_id      (bank),
      .dram_wr_data      (wr_data),
      .dram_rd_data      (rd_data),
      .dram_refresh_done (refresh_done),
      .bank_open         (bank_open),
      .cmd_error         (cmd_error)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic en, input logic csn, input logic [2:0] c,
                        input logic [2:0] b, input logic [6:0] a, input logic [7:0] d);
      clk_en = en;
      cs_n   = csn;
      {ras_n, cas_n, we_n} = c;
      bank    = b;
      addr    = a;
      wr_data = d;
   endtask

   task automatic tick();
      @(posedge u_clk);
      #1;
   endtask

   // ---------------- transaction-level reference model ----------------
   // Time is counted in enabled cycles; a refresh issued at enabled cycle k
   // occupies cycles k+1..k+RC and its done pulse is visible in cycle k+RC.
   bit         m_open [8];
   int         m_row  [8];
   logic [7:0] m_mem  [int];
   logic [7:0] m_rd;
   bit         m_known, m_err, m_done, m_ref_active;
   longint     m_cur, m_done_idx;

   function automatic int key(input int b, input int r, input int c);
      return (b * ROWS + r) * COLS + c;
   endfunction

   function automatic logic [7:0] m_open_mask();
      logic [7:0] m = '0;
      for (int i = 0; i < 8; i++) m[i] = m_open[i];
      return m;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_open[i] = 0;
      m_rd = '0; m_known = 1; m_err = 0; m_done = 0;
      m_ref_active = 0; m_cur = 0; m_done_idx = 0;
   endtask

   task automatic model_step(input logic en, input logic csn, input logic [2:0] c,
                             input int b, input int a, input logic [7:0] d);
      bit busy;
      int k;
      if (!en) return;
      busy  = m_ref_active && (m_cur <= m_done_idx);
      m_err = 0;
      if (!csn) begin
         if (busy) begin
            if (c != CMD_NOP && c != CMD_REF) m_err = 1;
         end else begin
            case (c)
               CMD_NOP: ;
               CMD_ACT: if (m_open[b]) m_err = 1;
                        else begin m_open[b] = 1; m_row[b] = a % ROWS; end
               CMD_RD: begin
                  if (!m_open[b]) m_err = 1;
                  else begin
                     k = key(b, m_row[b], a % COLS);
                     if (m_mem.exists(k)) begin m_rd = m_mem[k]; m_known = 1; end
                     else m_known = 0;
                  end
               end
               CMD_WR: if (!m_open[b]) m_err = 1;
                       else m_mem[key(b, m_row[b], a % COLS)] = d;
               CMD_PRE: m_open[b] = 0;
               CMD_REF: begin
                  for (int i = 0; i < 8; i++) m_open[i] = 0;
                  m_ref_active = 1;
                  m_done_idx   = m_cur + RC;
               end
               default: m_err = 1;
            endcase
         end
      end
      m_cur++;
      m_done = m_ref_active && (m_cur == m_done_idx);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic       en;
      logic       csn;
      logic [2:0] cmd;
      logic [2:0] bank;
      logic [6:0] addr;
      logic [7:0] wd;
      logic [7:0] e_open;
      logic       e_err;
      logic       e_done;
      logic [7:0] e_rd;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t v(input logic en, input logic csn, input logic [2:0] c,
                              input logic [2:0] b, input logic [6:0] a, input logic [7:0] d,
                              input logic [7:0] eo, input logic ee, input logic ed,
                              input logic [7:0] er);
      vec_t r;
      r.en = en; r.csn = csn; r.cmd = c; r.bank = b; r.addr = a; r.wd = d;
      r.e_open = eo; r.e_err = ee; r.e_done = ed; r.e_rd = er;
      return r;
   endfunction

   initial begin
      logic [2:0] c;
      logic [2:0] b;
      logic [6:0] a;
      logic [7:0] d;
      logic       en, csn;
      int         r;

      // Open/write/close/reopen/read round trip
      vecs.push_back(v(1,0,CMD_ACT,2,7'h15,8'h00, 8'h04,0,0,8'h00));
      vecs.push_back(v(1,0,CMD_WR ,2,7'h03,8'hA5, 8'h04,0,0,8'h00));
      vecs.push_back(v(1,0,CMD_PRE,2,7'h00,8'h00, 8'h00,0,0,8'h00));
      vecs.push_back(v(1,0,CMD_ACT,2,7'h15,8'h00, 8'h04,0,0,8'h00));
      vecs.push_back(v(1,0,CMD_RD ,2,7'h03,8'h00, 8'h04,0,0,8'hA5));
      vecs.push_back(v(1,0,CMD_NOP,0,7'h00,8'h00, 8'h04,0,0,8'hA5));
      // Closed-bank read, double activate keeps first row
      vecs.push_back(v(1,0,CMD_RD ,5,7'h01,8'h00, 8'h04,1,0,8'hA5));
      vecs.push_back(v(1,0,CMD_NOP,0,7'h00,8'h00, 8'h04,0,0,8'hA5));
      vecs.push_back(v(1,0,CMD_ACT,5,7'h22,8'h00, 8'h24,0,0,8'hA5));
      vecs.push_back(v(1,0,CMD_WR ,5,7'h01,8'h5C, 8'h24,0,0,8'hA5));
      vecs.push_back(v(1,0,CMD_ACT,5,7'h33,8'h00, 8'h24,1,0,8'hA5));
      vecs.push_back(v(1,0,CMD_RD ,5,7'h01,8'h00, 8'h24,0,0,8'h5C));
      vecs.push_back(v(1,0,CMD_RD ,2,7'h7B,8'h00, 8'h24,0,0,8'hA5)); // upper addr bits ignored
      // Refresh held until done, ACT during refresh, immediate re-refresh
      vecs.push_back(v(1,0,CMD_ACT,0,7'h01,8'h00, 8'h25,0,0,8'hA5));
      vecs.push_back(v(1,0,CMD_ACT,1,7'h02,8'h00, 8'h27,0,0,8'hA5));
      vecs.push_back(v(1,0,CMD_ACT,7,7'h03,8'h00, 8'hA7,0,0,8'hA5));
      vecs.push_back(v(1,0,CMD_REF,0,7'h00,8'h00, 8'h00,0,0,8'hA5)); // T
      vecs.push_back(v(1,0,CMD_REF,0,7'h00,8'h00, 8'h00,0,0,8'hA5));
      vecs.push_back(v(1,0,CMD_REF,0,7'h00,8'h00, 8'h00,0,0,8'hA5));
      vecs.push_back(v(1,0,CMD_ACT,3,7'h04,8'h00, 8'h00,1,1,8'hA5)); // done in T+4
      vecs.push_back(v(1,0,CMD_REF,0,7'h00,8'h00, 8'h00,0,0,8'hA5)); // continuation
      vecs.push_back(v(1,0,CMD_REF,0,7'h00,8'h00, 8'h00,0,0,8'hA5)); // new refresh T'
      vecs.push_back(v(1,0,CMD_NOP,0,7'h00,8'h00, 8'h00,0,0,8'hA5));
      vecs.push_back(v(1,0,CMD_NOP,0,7'h00,8'h00, 8'h00,0,0,8'hA5));
      vecs.push_back(v(1,0,CMD_NOP,0,7'h00,8'h00, 8'h00,0,1,8'hA5)); // done in T'+4
      vecs.push_back(v(1,0,CMD_NOP,0,7'h00,8'h00, 8'h00,0,0,8'hA5));
      // Clock enable stalls refresh by exactly the frozen cycles
      vecs.push_back(v(1,0,CMD_ACT,4,7'h09,8'h00, 8'h10,0,0,8'hA5));
      vecs.push_back(v(1,0,CMD_WR ,4,7'h02,8'h11, 8'h10,0,0,8'hA5));
      vecs.push_back(v(1,0,CMD_REF,0,7'h00,8'h00, 8'h00,0,0,8'hA5)); // T
      vecs.push_back(v(1,0,CMD_NOP,0,7'h00,8'h00, 8'h00,0,0,8'hA5));
      vecs.push_back(v(0,0,CMD_NOP,0,7'h00,8'h00, 8'h00,0,0,8'hA5));
      vecs.push_back(v(0,0,CMD_WR ,4,7'h02,8'hEE, 8'h00,0,0,8'hA5));
      vecs.push_back(v(0,0,CMD_NOP,0,7'h00,8'h00, 8'h00,0,0,8'hA5));
      vecs.push_back(v(1,0,CMD_NOP,0,7'h00,8'h00, 8'h00,0,0,8'hA5));
      vecs.push_back(v(1,0,CMD_NOP,0,7'h00,8'h00, 8'h00,0,1,8'hA5)); // done in T+7
      vecs.push_back(v(1,0,CMD_NOP,0,7'h00,8'h00, 8'h00,0,0,8'hA5));
      vecs.push_back(v(1,0,CMD_ACT,4,7'h09,8'h00, 8'h10,0,0,8'hA5));
      vecs.push_back(v(1,0,CMD_RD ,4,7'h02,8'h00, 8'h10,0,0,8'h11));
      vecs.push_back(v(0,0,CMD_WR ,4,7'h02,8'hEE, 8'h10,0,0,8'h11)); // frozen write
      vecs.push_back(v(1,0,CMD_RD ,4,7'h02,8'h00, 8'h10,0,0,8'h11));
      // Illegal encodings and deselected bus
      vecs.push_back(v(1,0,3'b000 ,4,7'h02,8'h00, 8'h10,1,0,8'h11));
      vecs.push_back(v(1,0,3'b110 ,4,7'h02,8'h00, 8'h10,1,0,8'h11));
      vecs.push_back(v(1,0,CMD_NOP,0,7'h00,8'h00, 8'h10,0,0,8'h11));
      vecs.push_back(v(1,1,CMD_ACT,0,7'h05,8'h00, 8'h10,0,0,8'h11));

      // Reset state
      drive(1, 1, CMD_NOP, 0, 0, 0);
      rst_n = 1'b0;
      tick(); tick();
      chk("reset_rd_data", rd_data, 0);
      chk("reset_done", refresh_done, 0);
      chk("reset_bank_open", bank_open, 0);
      chk("reset_cmd_error", cmd_error, 0);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         drive(vecs[i].en, vecs[i].csn, vecs[i].cmd, vecs[i].bank, vecs[i].addr, vecs[i].wd);
         tick();
         chk($sformatf("vec%0d_bank_open", i), bank_open, vecs[i].e_open);
         chk($sformatf("vec%0d_cmd_error", i), cmd_error, vecs[i].e_err);
         chk($sformatf("vec%0d_done", i), refresh_done, vecs[i].e_done);
         chk($sformatf("vec%0d_rd_data", i), rd_data, vecs[i].e_rd);
      end

      // Reset in the middle of a refresh
      drive(1, 0, CMD_ACT, 6, 7'h01, 0); tick();
      chk("midrst_open_pre", bank_open, 8'h50);
      drive(1, 0, CMD_REF, 0, 0, 0); tick();
      drive(1, 0, CMD_NOP, 0, 0, 0); tick();
      rst_n = 1'b0;
      drive(1, 0, CMD_REF, 0, 0, 0); tick();
      chk("midrst_done", refresh_done, 0);
      chk("midrst_open", bank_open, 0);
      chk("midrst_rd", rd_data, 0);
      chk("midrst_err", cmd_error, 0);
      rst_n = 1'b1;
      drive(1, 0, CMD_NOP, 0, 0, 0); tick();
      chk("midrst_no_late_done", refresh_done, 0);
      drive(1, 0, CMD_ACT, 6, 7'h01, 0); tick();
      chk("midrst_idle_act_open", bank_open, 8'h40);
      chk("midrst_idle_act_err", cmd_error, 0);

      // Random traffic against the model
      rst_n = 1'b0;
      drive(1, 1, CMD_NOP, 0, 0, 0); tick();
      rst_n = 1'b1;
      model_reset();
      for (int n = 0; n < 3000; n++) begin
         en  = ($urandom_range(0, 9) != 0);
         csn = ($urandom_range(0, 9) == 0);
         b   = 3'($urandom_range(0, 3));
         d   = 8'($urandom);
         r   = $urandom_range(0, 99);
         a   = 7'($urandom_range(0, 127));
         if      (r < 25) begin c = CMD_ACT; a = 7'($urandom_range(0, 3)); end
         else if (r < 45) c = CMD_RD;
         else if (r < 65) c = CMD_WR;
         else if (r < 80) c = CMD_PRE;
         else if (r < 86) c = CMD_REF;
         else if (r < 92) c = CMD_NOP;
         else if (r < 96) c = 3'b000;
         else             c = 3'b110;
         drive(en, csn, c, b, a, d);
         if ($urandom_range(0, 99) == 0) begin
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
            model_reset();
         end else begin
            tick();
            model_step(en, csn, c, int'(b), int'(a), d);
         end
         chk($sformatf("rnd%0d_bank_open", n), bank_open, m_open_mask());
         chk($sformatf("rnd%0d_cmd_error", n), cmd_error, m_err);
         chk($sformatf("rnd%0d_done", n), refresh_done, m_done);
         if (m_known) chk($sformatf("rnd%0d_rd_data", n), rd_data, m_rd);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
